// File: rtl/transmission_estimator_if.sv
// Bus between ale_top, the transmission estimator and the recovery stage.
// The master drives atmospheric light and pixels; the slave (estimator) returns
// the dark channel and transmission stream.
interface transmission_estimator_if;
  logic [7:0]  a_r;
  logic [7:0]  a_g;
  logic [7:0]  a_b;
  logic [15:0] inv_a_r;
  logic [15:0] inv_a_g;
  logic [15:0] inv_a_b;
  logic        ale_valid;
  logic [23:0] input_pixel;
  logic        input_is_valid;
  logic        input_ready;
  logic [7:0]  dark_out;
  logic [7:0]  t_out;
  logic        t_valid;
  logic        frame_done;

  modport master (
    output a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b, ale_valid,
    output input_pixel, input_is_valid,
    input  input_ready, dark_out, t_out, t_valid, frame_done
  );

  modport slave (
    input  a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b, ale_valid,
    input  input_pixel, input_is_valid,
    output input_ready, dark_out, t_out, t_valid, frame_done
  );
endinterface

// File: rtl/transmission_estimator.sv
// Transmission estimator: normalized 3x3 dark channel and t = 1 - omega*dark.
// Optional macro TE_T_MIN_CLAMP_EN floors t_out at T_MIN.
// Samples (pixels, then WIDTH+1 pads) flow through a valid-tagged 4-stage
// pipeline; the window only advances on valid samples, so input gaps pass
// straight through as output gaps and latency is always 4 cycles.
module transmission_estimator #(
  parameter int WIDTH  = 512,
  parameter int HEIGHT = 512,
  parameter int OMEGA  = 243,
  parameter int T_MIN  = 26
) (
  input logic                      clk,
  input logic                      rst,
  transmission_estimator_if.slave  bus
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int CW   = $clog2(WIDTH);
  localparam int RW   = $clog2(HEIGHT);
  localparam int PW   = $clog2(NPIX + 1);
  localparam int DW   = $clog2(WIDTH + 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [DW-1:0] pad_cnt_q, pad_cnt_d;
  logic [15:0]   inv_r_q, inv_g_q, inv_b_q;
  logic [15:0]   inv_r_d, inv_g_d, inv_b_d;

  logic in_fire, pad_fire, frame_start;

  // stage 1: raw sample
  logic        s1_valid_q, s1_pad_q;
  logic [23:0] s1_pix_q;
  // stage 2: per-pixel normalized minimum
  logic        s2_valid_q;
  logic [7:0]  s2_m_q;
  logic [23:0] prod_r, prod_g, prod_b;
  logic [7:0]  n_r, n_g, n_b, m_d;
  // stage 3: line buffers and window
  logic [7:0]    lb_a_q [0:WIDTH-1];
  logic [7:0]    lb_b_q [0:WIDTH-1];
  logic [7:0]    win_q  [0:2][0:2];
  logic [CW-1:0] scol_q, ccol_q, w3_col_q;
  logic [RW-1:0] crow_q, w3_row_q;
  logic [DW-1:0] prime_q;
  logic          w3_emit_q;
  // stage 4: outputs
  logic [7:0]  dark_d, t_raw, t_d, dark_q, t_q;
  logic [15:0] omega_prod;
  logic        t_valid_q, frame_done_q, frame_done_d;

  assign in_fire     = (state_q == RUN) && bus.input_is_valid;
  assign pad_fire    = (state_q == FLUSH) && (pad_cnt_q != DW'(WIDTH + 1));
  assign frame_start = (state_q == IDLE) && bus.ale_valid;

  assign bus.input_ready = (state_q == RUN);
  assign bus.dark_out    = dark_q;
  assign bus.t_out       = t_q;
  assign bus.t_valid     = t_valid_q;
  assign bus.frame_done  = frame_done_q;

  // Frame control: latch 1/A on start, count pixels in, pads during flush
  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    pad_cnt_d = pad_cnt_q;
    inv_r_d   = inv_r_q;
    inv_g_d   = inv_g_q;
    inv_b_d   = inv_b_q;
    case (state_q)
      IDLE: if (bus.ale_valid) begin
        state_d   = RUN;
        inv_r_d   = bus.inv_a_r;
        inv_g_d   = bus.inv_a_g;
        inv_b_d   = bus.inv_a_b;
        pix_cnt_d = '0;
        pad_cnt_d = '0;
      end
      RUN: if (in_fire) begin
        pix_cnt_d = pix_cnt_q + PW'(1);
        if (pix_cnt_q == PW'(NPIX - 1)) state_d = FLUSH;
      end
      FLUSH: begin
        if (pad_fire) pad_cnt_d = pad_cnt_q + DW'(1);
        if (frame_done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pix_cnt_q <= '0;
      pad_cnt_q <= '0;
      inv_r_q   <= '0;
      inv_g_q   <= '0;
      inv_b_q   <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      pad_cnt_q <= pad_cnt_d;
      inv_r_q   <= inv_r_d;
      inv_g_q   <= inv_g_d;
      inv_b_q   <= inv_b_d;
    end
  end

  // Stage 1: capture accepted pixel or injected pad
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_pad_q   <= 1'b0;
      s1_pix_q   <= '0;
    end else begin
      s1_valid_q <= in_fire || pad_fire;
      s1_pad_q   <= pad_fire;
      s1_pix_q   <= bus.input_pixel;
    end
  end

  // Normalize each channel by A (truncated, saturated) and take the minimum
  always_comb begin
    prod_r = {8'd0, s1_pix_q[23:16]} * {8'd0, inv_r_q};
    prod_g = {8'd0, s1_pix_q[15:8]}  * {8'd0, inv_g_q};
    prod_b = {8'd0, s1_pix_q[7:0]}   * {8'd0, inv_b_q};
    n_r = (|prod_r[23:16]) ? 8'hFF : prod_r[15:8];
    n_g = (|prod_g[23:16]) ? 8'hFF : prod_g[15:8];
    n_b = (|prod_b[23:16]) ? 8'hFF : prod_b[15:8];
    m_d = n_r;
    if (n_g < m_d) m_d = n_g;
    if (n_b < m_d) m_d = n_b;
    if (s1_pad_q) m_d = 8'hFF;
  end

  // Stage 2: register per-pixel minimum
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_m_q     <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_m_q     <= m_d;
    end
  end

  // Stage 3: shift window and line buffers; once WIDTH+1 samples are in,
  // every new sample completes the window of the centre WIDTH+1 behind it
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        lb_a_q[i] <= '0;
        lb_b_q[i] <= '0;
      end
      for (int unsigned i = 0; i < 3; i++)
        for (int unsigned j = 0; j < 3; j++)
          win_q[i][j] <= '0;
      scol_q    <= '0;
      ccol_q    <= '0;
      crow_q    <= '0;
      prime_q   <= '0;
      w3_emit_q <= 1'b0;
      w3_row_q  <= '0;
      w3_col_q  <= '0;
    end else begin
      w3_emit_q <= 1'b0;
      if (frame_start) begin
        scol_q  <= '0;
        ccol_q  <= '0;
        crow_q  <= '0;
        prime_q <= '0;
      end else if (s2_valid_q) begin
        lb_a_q[scol_q] <= s2_m_q;
        lb_b_q[scol_q] <= lb_a_q[scol_q];
        for (int unsigned i = 0; i < 3; i++) begin
          win_q[i][0] <= win_q[i][1];
          win_q[i][1] <= win_q[i][2];
        end
        win_q[0][2] <= lb_b_q[scol_q];
        win_q[1][2] <= lb_a_q[scol_q];
        win_q[2][2] <= s2_m_q;
        scol_q <= (scol_q == CW'(WIDTH - 1)) ? '0 : scol_q + CW'(1);
        if (prime_q == DW'(WIDTH + 1)) begin
          w3_emit_q <= 1'b1;
          w3_row_q  <= crow_q;
          w3_col_q  <= ccol_q;
          if (ccol_q == CW'(WIDTH - 1)) begin
            ccol_q <= '0;
            crow_q <= crow_q + RW'(1);
          end else begin
            ccol_q <= ccol_q + CW'(1);
          end
        end else begin
          prime_q <= prime_q + DW'(1);
        end
      end
    end
  end

  // Window minimum with off-frame neighbours masked out, then transmission
  always_comb begin
    dark_d = 8'hFF;
    for (int unsigned i = 0; i < 3; i++)
      for (int unsigned j = 0; j < 3; j++)
        if (!((i == 0 && w3_row_q == '0) ||
              (i == 2 && w3_row_q == RW'(HEIGHT - 1)) ||
              (j == 0 && w3_col_q == '0) ||
              (j == 2 && w3_col_q == CW'(WIDTH - 1))))
          if (win_q[i][j] < dark_d) dark_d = win_q[i][j];
    omega_prod = 16'(OMEGA) * {8'd0, dark_d};
    t_raw      = 8'hFF - omega_prod[15:8];
`ifdef TE_T_MIN_CLAMP_EN
    t_d = (t_raw < 8'(T_MIN)) ? 8'(T_MIN) : t_raw;
`else
    t_d = t_raw;
`endif
    frame_done_d = w3_emit_q && (w3_row_q == RW'(HEIGHT - 1)) &&
                   (w3_col_q == CW'(WIDTH - 1));
  end

  // Stage 4: output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dark_q       <= '0;
      t_q          <= '0;
      t_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      t_valid_q    <= w3_emit_q;
      frame_done_q <= frame_done_d;
      if (w3_emit_q) begin
        dark_q <= dark_d;
        t_q    <= t_d;
      end
    end
  end

endmodule

// File: tb/tb_transmission_estimator.sv
// Directed testbench for transmission_estimator (8x4 frame).
module tb_transmission_estimator;
  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;
`ifdef TE_T_MIN_CLAMP_EN
  localparam logic [7:0] T_WHITE = 8'd26;
`else
  localparam logic [7:0] T_WHITE = 8'd13;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  transmission_estimator_if bus ();

  transmission_estimator #(
    .WIDTH (W),
    .HEIGHT(H),
    .OMEGA (243),
    .T_MIN (26)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  rec_dark [$];
  logic [7:0]  rec_t    [$];
  logic        rec_fd   [$];
  logic [23:0] pix      [0:N-1];

  // Record every output beat
  always @(negedge clk) begin
    if (bus.t_valid) begin
      rec_dark.push_back(bus.dark_out);
      rec_t.push_back(bus.t_out);
      rec_fd.push_back(bus.frame_done);
    end
  end

  task automatic clear_rec();
    rec_dark.delete();
    rec_t.delete();
    rec_fd.delete();
  endtask

  task automatic pulse_ale(input logic [7:0] a, input logic [15:0] inv);
    @(negedge clk);
    bus.a_r = a; bus.a_g = a; bus.a_b = a;
    bus.inv_a_r = inv; bus.inv_a_g = inv; bus.inv_a_b = inv;
    bus.ale_valid = 1'b1;
    @(negedge clk);
    bus.ale_valid = 1'b0;
  endtask

  // Present pix[0..count-1]; gap is the percent chance of an idle cycle;
  // a second ale_valid (A=100) is raised alongside pixel ale_at
  task automatic feed(input int count, input int gap, input int ale_at);
    int idx = 0;
    int guard = 0;
    bit v;
    while (idx < count && guard < 2000) begin
      @(negedge clk);
      guard++;
      v = ($urandom_range(0, 99) >= gap);
      bus.input_pixel    = pix[idx];
      bus.input_is_valid = v;
      bus.ale_valid      = v && (idx == ale_at);
      if (idx == ale_at) begin
        bus.a_r = 8'd100; bus.a_g = 8'd100; bus.a_b = 8'd100;
        bus.inv_a_r = 16'd655; bus.inv_a_g = 16'd655; bus.inv_a_b = 16'd655;
      end
      if (v && bus.input_ready) idx++;
    end
    @(negedge clk);
    bus.input_is_valid = 1'b0;
    bus.ale_valid      = 1'b0;
    n_checks++;
    if (idx !== count) begin
      n_fail++;
      $display("FAIL feed_accept: accepted %0d required %0d", idx, count);
    end
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (!bus.frame_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (!bus.frame_done) begin
      n_fail++;
      $display("FAIL frame_done_timeout: got 0 required 1");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.ale_valid = 1'b0; bus.input_is_valid = 1'b0; bus.input_pixel = '0;
    bus.a_r = '0; bus.a_g = '0; bus.a_b = '0;
    bus.inv_a_r = '0; bus.inv_a_g = '0; bus.inv_a_b = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks += 5;
    if (bus.t_valid !== 1'b0)     begin n_fail++; $display("FAIL reset_t_valid: got %b required 0", bus.t_valid); end
    if (bus.dark_out !== 8'd0)    begin n_fail++; $display("FAIL reset_dark: got %0d required 0", bus.dark_out); end
    if (bus.t_out !== 8'd0)       begin n_fail++; $display("FAIL reset_t: got %0d required 0", bus.t_out); end
    if (bus.frame_done !== 1'b0)  begin n_fail++; $display("FAIL reset_frame_done: got %b required 0", bus.frame_done); end
    if (bus.input_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", bus.input_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_uniform(input string name, input int gap, input int ale_at);
    for (int i = 0; i < N; i++) pix[i] = 24'h6496C8;
    clear_rec();
    pulse_ale(8'd200, 16'd328);
    feed(N, gap, ale_at);
    wait_done();
    n_checks++;
    if (rec_dark.size() !== N) begin
      n_fail++;
      $display("FAIL %s_count: got %0d required %0d", name, rec_dark.size(), N);
    end
    for (int i = 0; i < rec_dark.size() && i < N; i++) begin
      n_checks += 3;
      if (rec_dark[i] !== 8'd128) begin n_fail++; $display("FAIL %s_dark[%0d]: got %0d required 128", name, i, rec_dark[i]); end
      if (rec_t[i] !== 8'd134)    begin n_fail++; $display("FAIL %s_t[%0d]: got %0d required 134", name, i, rec_t[i]); end
      if (rec_fd[i] !== (i == N - 1)) begin n_fail++; $display("FAIL %s_fd[%0d]: got %b required %b", name, i, rec_fd[i], (i == N - 1)); end
    end
  endtask

  // White frame with one black pixel at (zr,zc)
  task automatic test_black_pixel(input string name, input int zr, input int zc, input int gap);
    logic [7:0] ed, et;
    for (int i = 0; i < N; i++) pix[i] = 24'hFFFFFF;
    pix[zr * W + zc] = 24'h000000;
    clear_rec();
    pulse_ale(8'd255, 16'd257);
    feed(N, gap, -1);
    wait_done();
    n_checks++;
    if (rec_dark.size() !== N) begin
      n_fail++;
      $display("FAIL %s_count: got %0d required %0d", name, rec_dark.size(), N);
    end
    for (int i = 0; i < rec_dark.size() && i < N; i++) begin
      int r = i / W;
      int c = i % W;
      bit hit = (r >= zr - 1) && (r <= zr + 1) && (c >= zc - 1) && (c <= zc + 1);
      ed = hit ? 8'd0 : 8'd255;
      et = hit ? 8'd255 : T_WHITE;
      n_checks += 3;
      if (rec_dark[i] !== ed) begin n_fail++; $display("FAIL %s_dark(%0d,%0d): got %0d required %0d", name, r, c, rec_dark[i], ed); end
      if (rec_t[i] !== et)    begin n_fail++; $display("FAIL %s_t(%0d,%0d): got %0d required %0d", name, r, c, rec_t[i], et); end
      if (rec_fd[i] !== (i == N - 1)) begin n_fail++; $display("FAIL %s_fd(%0d,%0d): got %b required %b", name, r, c, rec_fd[i], (i == N - 1)); end
    end
  endtask

  task automatic test_handshake();
    clear_rec();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.input_pixel = 24'h6496C8;
      bus.input_is_valid = 1'b1;
      n_checks++;
      if (bus.input_ready !== 1'b0) begin n_fail++; $display("FAIL pre_ale_ready: got %b required 0", bus.input_ready); end
    end
    @(negedge clk);
    bus.input_is_valid = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (rec_dark.size() !== 0) begin n_fail++; $display("FAIL pre_ale_outputs: got %0d required 0", rec_dark.size()); end
    test_uniform("second_ale", 0, 10);
  endtask

  task automatic test_rst_midframe();
    for (int i = 0; i < N; i++) pix[i] = 24'hFFFFFF;
    clear_rec();
    pulse_ale(8'd255, 16'd257);
    feed(13, 0, -1);
    rst = 1'b1;
    @(negedge clk);
    clear_rec();
    n_checks += 4;
    if (bus.t_valid !== 1'b0)     begin n_fail++; $display("FAIL midrst_t_valid: got %b required 0", bus.t_valid); end
    if (bus.dark_out !== 8'd0)    begin n_fail++; $display("FAIL midrst_dark: got %0d required 0", bus.dark_out); end
    if (bus.t_out !== 8'd0)       begin n_fail++; $display("FAIL midrst_t: got %0d required 0", bus.t_out); end
    if (bus.input_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b required 0", bus.input_ready); end
    rst = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (rec_dark.size() !== 0) begin n_fail++; $display("FAIL midrst_outputs: got %0d required 0", rec_dark.size()); end
    test_uniform("after_rst", 0, -1);
  endtask

  initial begin
    test_reset();
    test_uniform("uniform", 0, -1);
    test_black_pixel("center", 2, 5, 0);
    test_black_pixel("corner", 0, 0, 0);
    test_handshake();
    test_rst_midframe();
    test_black_pixel("gaps", 2, 5, 30);
    test_uniform("uniform_gaps", 30, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/transmission_estimator.md
Name: transmission_estimator

Overview:
- Downstream neighbour of ale_top in the haze-removal pipeline.
- Latches the atmospheric light A and 1/A produced by ale_top, then streams the frame in raster order.
- Per pixel, normalizes each channel by A and takes the minimum over channels and over a 3x3 window (normalized dark channel).
- Emits transmission t = 1 - omega*dark as 8-bit fixed point, in raster order, for the recovery stage.

Parameters:
- WIDTH, 512, pixels per line (>=2).
- HEIGHT, 512, lines per frame (>=2).
- OMEGA, 243, haze-retention factor, Q0.8 (243 ~ 0.95).
- T_MIN, 26, transmission floor, Q0.8 (26 ~ 0.1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- a_r, a_g, a_b  in  8 each  atmospheric light from ale_top.
- inv_a_r, inv_a_g, inv_a_b  in  16 each  1/A in Q0.16, i.e. round(65536/A) saturated to 65535.
- ale_valid  in  1  one-cycle strobe; A and inv_A are valid this cycle.
- input_pixel  in  24  {R[23:16], G[15:8], B[7:0]}.
- input_is_valid  in  1  input_pixel valid this cycle.
- input_ready  out  1  high only in RUN; pixels presented while low are dropped.
- dark_out  out  8  3x3 normalized dark channel for the current output pixel.
- t_out  out  8  transmission, Q0.8.
- t_valid  out  1  dark_out and t_out are valid this cycle.
- frame_done  out  1  one-cycle pulse with the last (WIDTH*HEIGHT-th) output.

Behaviour:
- Reset: all outputs 0; state IDLE; row/col counters, pipeline and line buffers cleared.
- rst mid-frame aborts the frame with no further t_valid; the latched A is discarded.
- FSM states: IDLE, RUN, FLUSH.
- IDLE -> RUN on ale_valid. Latch inv_a_* that cycle. input_ready rises the next cycle.
- RUN -> FLUSH after WIDTH*HEIGHT accepted pixels. ale_valid in RUN or FLUSH is ignored; A stays frozen for the frame.
- FLUSH: internally injects WIDTH+1 pad samples, one per cycle, to complete the last row's windows. input_ready=0.
- FLUSH -> IDLE on the cycle after frame_done.
- Normalize: n_c = min(255, (I_c*inv_a_c)>>8). The 24-bit product is truncated, not rounded.
- Per-pixel minimum: m = min(n_r, n_g, n_b).
- Window: two line buffers of WIDTH x 8 bits plus a 3x3 register window.
- Border handling: out-of-frame neighbours read as 255, the neutral value for min. No wrap across lines or frames.
- dark = min of the 9 window samples.
- t = 255 - ((OMEGA*dark)>>8), truncated.
- Latency: t_valid for centre pixel (r,c) is asserted exactly 4 cycles after the cycle in which sample (r+1,c+1) entered. That sample is a real pixel or a pad, including off-frame positions.
- Output count: exactly WIDTH*HEIGHT t_valid cycles per frame, in raster order; t_valid gaps mirror input gaps.
- Gaps in input_is_valid during RUN stall the pipeline and add no bubbles of their own.

Optional Feature:
- Macro: TE_T_MIN_CLAMP_EN.
- Defined: t_out = max(t, T_MIN).
- Undefined: t_out = t unclamped; T_MIN is unused.
- dark_out is identical in both builds.

Test Plan:
- Params WIDTH=8, HEIGHT=4, clamp off.
  - A=(200,200,200), inv=328.
  - Uniform frame I=(R100, G150, B200).
  - Expect 32 outputs with dark_out=128, t_out=134.
  - frame_done pulses with output 32.
- White frame, A=255 (inv=257), pixel (2,5)=0.
  - Expect dark_out=0 and t_out=255 at rows 1-3, cols 4-6.
  - Elsewhere expect dark_out=255 and t_out=13.
  - With TE_T_MIN_CLAMP_EN, the elsewhere t_out=26.
- Corner: pixel (0,0)=0 in a white frame.
  - Only (0,0), (0,1), (1,0), (1,1) have dark_out=0.
  - (0,7) and (3,*) have dark_out=255, proving no wrap.
- Handshake and A latching:
  - Pixels presented before ale_valid are dropped (input_ready=0); no output.
  - A second ale_valid mid-frame with A=100 is ignored; results match the first A.
- rst asserted after 13 pixels: outputs go to 0, no t_valid.
  - A following ale_valid plus a full frame produces exactly 32 correct outputs.
- Random gaps on input_is_valid (~30%): output values and order match the gap-free run.
